// File: rtl/led_scan_ctrl.sv
// led_scan_ctrl: raster scan generator for the background LED matrix.
// Produces row/column coordinates for the region-judge stage plus the panel
// shift clock, latch and output-enable strobes. Each row runs SHIFT (one slot of
// CLK_DIV cycles per column), one LATCH cycle, then DISPLAY for ON_CYC cycles.
// Optional feature: define SCAN_SERPENTINE_EN to scan odd rows right-to-left.
module led_scan_ctrl #(
    parameter int ROWS    = 64,
    parameter int COLS    = 64,
    parameter int CLK_DIV = 4,
    parameter int ON_CYC  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic [6:0] row_now,
    output logic [6:0] col_now,
    output logic       pix_valid,
    output logic       led_sclk,
    output logic       led_lat,
    output logic       led_oe_n,
    output logic [6:0] row_sel,
    output logic       frame_done,
    output logic       busy
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int ON_W  = (ON_CYC > 1) ? $clog2(ON_CYC) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    // Last low cycle of a slot; the following cycle raises led_sclk.
    localparam logic [DIV_W-1:0] SCLK_RISE = DIV_W'(CLK_DIV / 2 - 1);
    localparam logic [ON_W-1:0]  ON_LAST   = ON_W'(ON_CYC - 1);
    localparam logic [6:0]       ROW_LAST  = 7'(ROWS - 1);
    localparam logic [6:0]       COL_LAST  = 7'(COLS - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DISPLAY} state_t;

    state_t           state, state_next;
    logic [DIV_W-1:0] div_cnt, div_next;
    logic [ON_W-1:0]  on_cnt, on_next;
    logic [6:0]       row_next, col_next, row_sel_next;
    logic             pix_next, sclk_next, lat_next, oe_n_next, frame_next;

    logic [6:0]       row_after;        // row that follows the current one
    logic             rev_cur;          // current row scans right-to-left
    logic             rev_after;        // following row scans right-to-left
    logic [6:0]       col_first_after;  // starting column of the following row
    logic [6:0]       col_end_cur;      // final column of the current row
    logic [6:0]       col_step_cur;     // next column within the current row

    assign row_after = (row_now == ROW_LAST) ? 7'd0 : row_now + 7'd1;

`ifdef SCAN_SERPENTINE_EN
    assign rev_cur   = row_now[0];
    assign rev_after = row_after[0];
`else
    assign rev_cur   = 1'b0;
    assign rev_after = 1'b0;
`endif

    assign col_first_after = rev_after ? COL_LAST : 7'd0;
    assign col_end_cur     = rev_cur ? 7'd0 : COL_LAST;
    assign col_step_cur    = rev_cur ? col_now - 7'd1 : col_now + 7'd1;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: registers take non-blocking assignments so every flop samples
            // the pre-edge values, independent of statement order.
            state <= state_next;
        end
    end

    // Next-state and next-output decode for the scan sequence.
    always_comb begin
        // NOTE: every target gets a default first, so no path leaves a value
        // unassigned and no latch is inferred.
        state_next   = state;
        row_next     = row_now;
        col_next     = col_now;
        row_sel_next = row_sel;
        div_next     = div_cnt;
        on_next      = on_cnt;
        pix_next     = 1'b0;
        sclk_next    = 1'b0;
        lat_next     = 1'b0;
        oe_n_next    = 1'b1;
        frame_next   = 1'b0;

        unique case (state)
            IDLE: begin
                if (en) begin
                    state_next = SHIFT;
                    row_next   = 7'd0;
                    col_next   = 7'd0;
                    div_next   = '0;
                    pix_next   = 1'b1;
                end
            end
            SHIFT: begin
                if (div_cnt == DIV_LAST) begin
                    div_next = '0;
                    if (col_now == col_end_cur) begin
                        state_next   = LATCH;
                        lat_next     = 1'b1;
                        row_sel_next = row_now;
                    end else begin
                        col_next = col_step_cur;
                        pix_next = 1'b1;
                    end
                end else begin
                    div_next  = div_cnt + 1'b1;
                    sclk_next = (div_cnt >= SCLK_RISE);
                end
            end
            LATCH: begin
                state_next = DISPLAY;
                on_next    = '0;
                oe_n_next  = 1'b0;
            end
            DISPLAY: begin
                if (on_cnt == ON_LAST) begin
                    row_next = row_after;
                    col_next = col_first_after;
                    div_next = '0;
                    if (row_now == ROW_LAST) begin
                        frame_next = 1'b1;
                        // en only matters here at the frame wrap.
                        if (en) begin
                            state_next = SHIFT;
                            pix_next   = 1'b1;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        state_next = SHIFT;
                        pix_next   = 1'b1;
                    end
                end else begin
                    on_next   = on_cnt + 1'b1;
                    oe_n_next = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Registered outputs and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_now    <= 7'd0;
            col_now    <= 7'd0;
            row_sel    <= 7'd0;
            pix_valid  <= 1'b0;
            led_sclk   <= 1'b0;
            led_lat    <= 1'b0;
            led_oe_n   <= 1'b1;
            frame_done <= 1'b0;
            busy       <= 1'b0;
            div_cnt    <= '0;
            on_cnt     <= '0;
        end else begin
            row_now    <= row_next;
            col_now    <= col_next;
            row_sel    <= row_sel_next;
            pix_valid  <= pix_next;
            led_sclk   <= sclk_next;
            led_lat    <= lat_next;
            led_oe_n   <= oe_n_next;
            frame_done <= frame_next;
            busy       <= (state_next != IDLE);
            div_cnt    <= div_next;
            on_cnt     <= on_next;
        end
    end

endmodule

// File: tb/tb_led_scan_ctrl.sv
// tb_led_scan_ctrl: self-checking bench for led_scan_ctrl (ROWS=4, COLS=4,
// CLK_DIV=2, ON_CYC=3). A frame-position model predicts every output each cycle;
// directed sections pin the model with literal timing values.
module tb_led_scan_ctrl;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int DIV  = 2;
    localparam int ON   = 3;
    localparam int SH   = COLS * DIV;       // shift cycles per row
    localparam int RP   = SH + 1 + ON;      // row period
    localparam int FP   = ROWS * RP;        // frame period

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [6:0] row_now, col_now, row_sel;
    logic       pix_valid, led_sclk, led_lat, led_oe_n, frame_done, busy;

    led_scan_ctrl #(.ROWS(ROWS), .COLS(COLS), .CLK_DIV(DIV), .ON_CYC(ON)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .row_now    (row_now),
        .col_now    (col_now),
        .pix_valid  (pix_valid),
        .led_sclk   (led_sclk),
        .led_lat    (led_lat),
        .led_oe_n   (led_oe_n),
        .row_sel    (row_sel),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit rev_row(input int r);
`ifdef SCAN_SERPENTINE_EN
        return (r % 2) == 1;
`else
        return (r < 0);
`endif
    endfunction

    // Model: running flag plus cycle position inside the frame.
    bit m_run;
    int m_pos;
    bit m_fd;
    int m_rsel;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run  <= 1'b0;
            m_pos  <= 0;
            m_fd   <= 1'b0;
            m_rsel <= 0;
        end else if (m_run) begin
            m_fd <= (m_pos == FP - 1);
            if (m_pos == FP - 1) begin
                m_pos <= 0;
                m_run <= en;
            end else begin
                m_pos <= m_pos + 1;
                if ((m_pos + 1) % RP == SH) m_rsel <= (m_pos + 1) / RP;
            end
        end else begin
            m_fd <= 1'b0;
            if (en) begin
                m_run <= 1'b1;
                m_pos <= 0;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        int r, off, slot, ph;
        int e_row, e_col;
        bit e_pix, e_sclk, e_lat, e_oe, e_busy;
        if (!m_run) begin
            e_row = 0; e_col = 0; e_pix = 0; e_sclk = 0; e_lat = 0; e_oe = 1; e_busy = 0;
        end else begin
            r      = m_pos / RP;
            off    = m_pos % RP;
            e_row  = r;
            e_busy = 1;
            if (off < SH) begin
                slot   = off / DIV;
                ph     = off % DIV;
                e_col  = rev_row(r) ? COLS - 1 - slot : slot;
                e_pix  = (ph == 0);
                e_sclk = (ph >= DIV / 2);
                e_lat  = 0;
                e_oe   = 1;
            end else begin
                e_col  = rev_row(r) ? 0 : COLS - 1;
                e_pix  = 0;
                e_sclk = 0;
                e_lat  = (off == SH);
                e_oe   = (off == SH);
            end
        end
        check("row_now", row_now, e_row);
        check("col_now", col_now, e_col);
        check("pix_valid", pix_valid, e_pix);
        check("led_sclk", led_sclk, e_sclk);
        check("led_lat", led_lat, e_lat);
        check("led_oe_n", led_oe_n, e_oe);
        check("busy", busy, e_busy);
        check("frame_done", frame_done, m_fd);
        check("row_sel", row_sel, m_rsel);
    end

    initial begin
        int first_lat = -1, n_lat = 0, rsel_lat3 = -1;
        int fd0 = -1, fd1 = -1, n_fd = 0, row_at_fd0 = -1;
        int rises = 0, bad_rise = 0, pix_r0 = 0, oe_low_r0 = 0, oe_bad = 0;
        int idle_pix = 0, idle_oe = 0, idle_busy = 0;
        logic [7:0] cols_r0 = '0, cols_r1 = '0;
        logic [7:0] exp_r1;
        logic prev_sclk;

`ifdef SCAN_SERPENTINE_EN
        exp_r1 = 8'hE4;   // cols 3,2,1,0
`else
        exp_r1 = 8'h1B;   // cols 0,1,2,3
`endif

        repeat (3) @(negedge clk);
        check("rst_oe_n", led_oe_n, 1);
        check("rst_busy", busy, 0);
        check("rst_row_col", {row_now, col_now}, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_busy", busy, 0);

        // Continuous scan: measure two frames of timing.
        en = 1'b1;
        @(negedge clk);
        check("first_pix", pix_valid, 1);
        check("first_coord", {row_now, col_now}, 0);
        prev_sclk = 1'b0;
        for (int c = 0; c <= 2 * FP; c++) begin
            if (c > 0) @(negedge clk);
            if (led_lat) begin
                if (first_lat < 0) first_lat = c;
                if (n_lat == 2) rsel_lat3 = row_sel;
                n_lat++;
            end
            if (frame_done) begin
                if (n_fd == 0) begin fd0 = c; row_at_fd0 = row_now; end
                else if (n_fd == 1) fd1 = c;
                n_fd++;
            end
            if (!led_oe_n && (c % RP) <= SH) oe_bad++;
            if (c < RP) begin
                if (led_sclk && !prev_sclk) begin
                    rises++;
                    if (c % DIV != 1) bad_rise++;
                end
                if (pix_valid) begin pix_r0++; cols_r0 = {cols_r0[5:0], col_now[1:0]}; end
                if (!led_oe_n) oe_low_r0++;
            end else if (c < 2 * RP && pix_valid) begin
                cols_r1 = {cols_r1[5:0], col_now[1:0]};
            end
            prev_sclk = led_sclk;
        end
        check("first_lat_cycle", first_lat, 8);
        check("lat_count", n_lat, 8);
        check("row_sel_row2", rsel_lat3, 2);
        check("frame_done_first", fd0, 48);
        check("frame_done_period", fd1 - fd0, 48);
        check("frame_done_count", n_fd, 2);
        check("row_wrap", row_at_fd0, 0);
        check("sclk_rises", rises, 4);
        check("sclk_rise_phase", bad_rise, 0);
        check("pix_row0", pix_r0, 4);
        check("cols_row0", cols_r0, 8'h1B);
        check("cols_row1", cols_r1, exp_r1);
        check("oe_low_row0", oe_low_r0, 3);
        check("oe_during_shift_latch", oe_bad, 0);

        // Drop en during row 1: the frame completes, then IDLE.
        for (int i = 0; i < 2 * FP && !(m_run && m_pos / RP == 1); i++) @(negedge clk);
        check("reach_row1", row_now, 1);
        en = 1'b0;
        for (int i = 0; i < 2 * FP && m_run; i++) @(negedge clk);
        check("idle_after_frame", busy, 0);
        check("idle_fd_pulse", frame_done, 1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (pix_valid) idle_pix++;
            if (!led_oe_n) idle_oe++;
            if (busy) idle_busy++;
        end
        check("idle_no_pix", idle_pix, 0);
        check("idle_oe_off", idle_oe, 0);
        check("idle_stays", idle_busy, 0);

        // Asynchronous reset in the middle of DISPLAY.
        en = 1'b1;
        for (int i = 0; i < 2 * FP && !(m_run && m_pos % RP > SH); i++) @(negedge clk);
        check("in_display", led_oe_n, 0);
        #2 rst_n = 1'b0;
        #1;
        check("async_oe_n", led_oe_n, 1);
        check("async_busy", busy, 0);
        check("async_coord", {row_now, col_now}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("restart_pix", pix_valid, 1);
        check("restart_coord", {row_now, col_now}, 0);

        // Randomized enable with occasional asynchronous reset pulses.
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            en = ($urandom_range(0, 99) < 80);
            if ($urandom_range(0, 399) == 0) begin
                #2 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
